// File: rtl/dma_copy_engine.sv
// dma_copy_engine: memory-to-memory word copier.
//
// A config port holds SRC, DST and LEN. Writing CTRL bit0 starts a copy: LEN words are read
// from SRC and written to DST, one word at a time, through a shared master port that needs a
// grant from an external arbiter. On completion, a one-cycle irq pulse fires and sticky DONE
// is set.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   we_i        config write enable
//   addr_i      config byte address (bits [3:2] select SRC/DST/LEN/CTRL)
//   wd_i        config write data
//   rd_o        config read data, registered (valid one cycle after addr_i)
//   bus_req_o   master-port request
//   bus_gnt_i   master-port grant
//   we_m_o      master write enable
//   addr_m_o    master byte address
//   wd_m_o      master write data
//   rd_m_i      master read data (valid one cycle after addr_m_o)
//   irq_o       completion pulse
module dma_copy_engine #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        we_m_o,
  output logic [31:0] addr_m_o,
  output logic [31:0] wd_m_o,
  input  logic [31:0] rd_m_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StFinish} state_e;

  state_e             state_q;
  logic [31:0]        src_q, dst_q;
  logic [LEN_W-1:0]   len_q;
  logic [31:0]        wsrc_q, wdst_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [31:0]        data_q;
  logic               busy_q, done_q, irq_q;
  logic [31:0]        rd_q, rd_d;
  logic [31:0]        addr_m_q, wd_m_q;

  logic [1:0] sel;
  logic       ctrl_wr, start, clr_done;
  logic       drive_rd, drive_wr;
  logic       unused_bits;

  assign sel         = addr_i[3:2];
  assign ctrl_wr     = we_i && (sel == 2'd3);
  assign start       = ctrl_wr && wd_i[0];
  assign clr_done    = ctrl_wr && wd_i[2];
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0]};

  assign drive_rd = (state_q == StRead) && bus_gnt_i;
  assign drive_wr = (state_q == StWrite) && bus_gnt_i;

  // Master address/data are driven only during a granted access and otherwise hold the last
  // value driven, which addr_m_q/wd_m_q remember.
  always_comb begin
    addr_m_o = addr_m_q;
    wd_m_o   = wd_m_q;
    if (drive_rd) begin
      addr_m_o = wsrc_q;
    end else if (drive_wr) begin
      addr_m_o = wdst_q;
      wd_m_o   = data_q;
    end
    we_m_o    = drive_wr;
    bus_req_o = (state_q == StRead) || (state_q == StWait) || (state_q == StWrite);
  end

  always_comb begin
    rd_d = 32'h0;
    unique case (sel)
      2'd0: rd_d = src_q;
      2'd1: rd_d = dst_q;
      2'd2: rd_d = 32'(len_q);
      2'd3: rd_d = {29'h0, done_q, busy_q, 1'b0};
      default: rd_d = 32'h0;
    endcase
  end

  assign rd_o  = rd_q;
  assign irq_o = irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      len_q    <= '0;
      wsrc_q   <= 32'h0;
      wdst_q   <= 32'h0;
      cnt_q    <= '0;
      data_q   <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      rd_q     <= 32'h0;
      addr_m_q <= 32'h0;
      wd_m_q   <= 32'h0;
    end else begin
      rd_q     <= rd_d;
      addr_m_q <= addr_m_o;
      wd_m_q   <= wd_m_o;
      irq_q    <= 1'b0;

      // Descriptor registers are frozen while a copy is in flight.
      if (we_i && !busy_q) begin
        case (sel)
          2'd0:    src_q <= {wd_i[31:2], 2'b00};
          2'd1:    dst_q <= {wd_i[31:2], 2'b00};
          2'd2:    len_q <= wd_i[LEN_W-1:0];
          default: ;
        endcase
      end

      // A completion in FINISH below overrides a clear in the same cycle.
      if (clr_done) begin
        done_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            if (len_q != '0) begin
              wsrc_q  <= src_q;
              wdst_q  <= dst_q;
              cnt_q   <= len_q;
              busy_q  <= 1'b1;
              state_q <= StRead;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StRead: begin
          if (bus_gnt_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // The read was issued in READ; grant here does not matter.
          data_q  <= rd_m_i;
          state_q <= StWrite;
        end
        StWrite: begin
          if (bus_gnt_i) begin
            wsrc_q  <= wsrc_q + 32'd4;
            wdst_q  <= wdst_q + 32'd4;
            cnt_q   <= cnt_q - LEN_W'(1);
            state_q <= (cnt_q > LEN_W'(1)) ? StRead : StFinish;
          end
        end
        StFinish: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          irq_q   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [31:0] addr_i, wd_i, rd_o;
  logic        bus_req_o, bus_gnt_i, we_m_o, irq_o;
  logic [31:0] addr_m_o, wd_m_o, rd_m_i;

  dma_copy_engine #(.LEN_W(16)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wd_i      (wd_i),
    .rd_o      (rd_o),
    .bus_req_o (bus_req_o),
    .bus_gnt_i (bus_gnt_i),
    .we_m_o    (we_m_o),
    .addr_m_o  (addr_m_o),
    .wd_m_o    (wd_m_o),
    .rd_m_i    (rd_m_i),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_seen = 0;
  int          cyc = 0;
  logic [31:0] salt;

  // Source memory content is a fixed bijective function of address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous-read memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk_i) rd_m_i <= mem_f(addr_m_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every master write is popped against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && we_m_o) begin
      wr_seen++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", addr_m_o, wd_m_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (addr_m_o !== e.a || wd_m_o !== e.d || bus_gnt_i !== 1'b1) begin
          n_fail++;
          $display("FAIL write: got addr %h data %h gnt %b expected addr %h data %h gnt 1",
                   addr_m_o, wd_m_o, bus_gnt_i, e.a, e.d);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_wr(input logic [1:0] r, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = {28'h0, r, 2'b00};
    wd_i   = d;
    @(posedge clk_i);
    #1;
    we_i = 1'b0;
  endtask

  task automatic cfg_rd(input logic [1:0] r, output logic [31:0] d);
    addr_i = {28'h0, r, 2'b00};
    @(posedge clk_i);
    #1;
    d = rd_o;
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] dd, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = dd + 32'(4 * i);
      e.d = mem_f(s + 32'(4 * i));
      exp_q.push_back(e);
    end
  endtask

  // Waits for irq. t_start is cyc-1 taken just after the start write, so the edge that
  // sampled the start counts as cycle 1. mode: 0 gnt high, 1 two 5-cycle stalls, 2 random.
  task automatic wait_irq(input string name, input int t_start, input int exp_lat,
                          input int mode);
    int lat;
    lat = cyc - t_start;
    while (!irq_o && lat < 300) begin
      case (mode)
        1:       bus_gnt_i = !((lat >= 1 && lat <= 5) || (lat >= 8 && lat <= 12));
        2:       bus_gnt_i = ($urandom_range(0, 3) != 0);
        default: bus_gnt_i = 1'b1;
      endcase
      @(posedge clk_i);
      #1;
      lat = cyc - t_start;
    end
    bus_gnt_i = 1'b1;
    chk({name, "_irq_seen"}, 32'(irq_o), 32'd1);
    if (exp_lat >= 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk_i);
    #1;
    chk({name, "_irq_pulse"}, 32'(irq_o), 32'd0);
    chk({name, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d, s, t;
    int          t0, base, n;

    salt      = $urandom;
    rst_ni    = 1'b0;
    we_i      = 1'b0;
    addr_i    = 32'h0;
    wd_i      = 32'h0;
    bus_gnt_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rd", rd_o, 32'h0);
    chk("rst_we_m", 32'(we_m_o), 32'h0);
    chk("rst_addr_m", addr_m_o, 32'h0);
    chk("rst_wd_m", wd_m_o, 32'h0);
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    rst_ni = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cfg_rd(2'(r), d);
      chk("rst_reg", d, 32'h0);
    end

    // Alignment and zero extension.
    cfg_wr(2'd0, 32'h0000_1003);
    cfg_rd(2'd0, d);
    chk("src_align", d, 32'h0000_1000);
    cfg_wr(2'd2, 32'hFFFF_ABCD);
    cfg_rd(2'd2, d);
    chk("len_zext", d, 32'h0000_ABCD);

    // Basic 4-word copy.
    cfg_wr(2'd0, 32'h0000_1000);
    cfg_wr(2'd1, 32'h0000_1100);
    cfg_wr(2'd2, 32'd4);
    push_copy(32'h1000, 32'h1100, 4);
    base = wr_seen;
    cfg_wr(2'd3, 32'h1);
    t0 = cyc - 1;
    wait_irq("copy4", t0, 14, 0);
    chk("copy4_nwrites", 32'(wr_seen - base), 32'd4);
    cfg_rd(2'd3, d);
    chk("copy4_status", d, 32'h4);

    // DONE clear, then zero-length copy.
    cfg_wr(2'd3, 32'h4);
    cfg_rd(2'd3, d);
    chk("done_clear", d, 32'h0);
    cfg_wr(2'd2, 32'd0);
    cfg_wr(2'd3, 32'h1);
    t0 = cyc - 1;
    wait_irq("len0", t0, 2, 0);
    cfg_rd(2'd3, d);
    chk("len0_status", d, 32'h4);

    // Start and DONE-clear in one write.
    s = $urandom & 32'hFFFF_FFFC;
    t = $urandom & 32'hFFFF_FFFC;
    cfg_wr(2'd0, s);
    cfg_wr(2'd1, t);
    cfg_wr(2'd2, 32'd3);
    push_copy(s, t, 3);
    cfg_wr(2'd3, 32'h5);
    t0 = cyc - 1;
    cfg_rd(2'd3, d);
    chk("startclr_busy", d, 32'h2);
    wait_irq("startclr", t0, 11, 0);

    // Start and descriptor writes while busy are ignored.
    cfg_wr(2'd0, 32'h0000_2000);
    cfg_wr(2'd1, 32'h0000_3000);
    cfg_wr(2'd2, 32'd4);
    push_copy(32'h2000, 32'h3000, 4);
    cfg_wr(2'd3, 32'h1);
    t0 = cyc - 1;
    cfg_wr(2'd0, 32'hDEAD_0000);
    cfg_wr(2'd2, 32'd7);
    cfg_wr(2'd3, 32'h1);
    wait_irq("busy_ign", t0, 14, 0);
    cfg_rd(2'd0, d);
    chk("busy_ign_src", d, 32'h0000_2000);
    cfg_rd(2'd2, d);
    chk("busy_ign_len", d, 32'd4);

    // Source address wraps through zero.
    cfg_wr(2'd0, 32'hFFFF_FFFC);
    cfg_wr(2'd1, 32'h0000_4000);
    cfg_wr(2'd2, 32'd2);
    push_copy(32'hFFFF_FFFC, 32'h4000, 2);
    cfg_wr(2'd3, 32'h1);
    t0 = cyc - 1;
    wait_irq("wrap", t0, 8, 0);

    // Grant stalls of 5 cycles in READ and in WRITE.
    cfg_wr(2'd0, 32'h0000_5000);
    cfg_wr(2'd1, 32'h0000_6000);
    push_copy(32'h5000, 32'h6000, 2);
    cfg_wr(2'd3, 32'h1);
    t0 = cyc - 1;
    wait_irq("stall", t0, 18, 1);

    // Randomized copies with random grant.
    for (int k = 0; k < 8; k++) begin
      s = $urandom & 32'hFFFF_FFFC;
      t = $urandom & 32'hFFFF_FFFC;
      n = $urandom_range(0, 6);
      cfg_wr(2'd0, s);
      cfg_wr(2'd1, t);
      cfg_wr(2'd2, 32'(n));
      push_copy(s, t, n);
      cfg_wr(2'd3, 32'h5);
      t0 = cyc - 1;
      wait_irq("rand", t0, -1, 2);
      cfg_rd(2'd3, d);
      chk("rand_status", d, 32'h4);
    end

    // Reset in the middle of an 8-word copy.
    cfg_wr(2'd0, 32'h0000_7000);
    cfg_wr(2'd1, 32'h0000_8000);
    cfg_wr(2'd2, 32'd8);
    push_copy(32'h7000, 32'h8000, 8);
    base = wr_seen;
    cfg_wr(2'd3, 32'h1);
    t0 = cyc;
    while (wr_seen - base < 2 && cyc - t0 < 100) begin
      @(posedge clk_i);
      #1;
    end
    chk("mid_two_writes", 32'(wr_seen - base), 32'd2);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_we_m", 32'(we_m_o), 32'h0);
    chk("mid_rst_addr_m", addr_m_o, 32'h0);
    chk("mid_rst_wd_m", wd_m_o, 32'h0);
    chk("mid_rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("mid_rst_irq", 32'(irq_o), 32'h0);
    chk("mid_rst_rd", rd_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    chk("mid_no_more_writes", 32'(wr_seen - base), 32'd2);
    chk("mid_no_irq", 32'(irq_o), 32'h0);
    cfg_rd(2'd3, d);
    chk("mid_status", d, 32'h0);
    cfg_rd(2'd0, d);
    chk("mid_src", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter LEN_W, default 16, width of the word-count register (copy of up to 2^LEN_W-1 words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 we  input  1  config-port write enable (responder side, driven by interconnect slave slot).
REQ-005 addr  input  32  config-port byte address; only bits [3:2] decoded.
REQ-006 wd  input  32  config-port write data.
REQ-007 rd  output  32  config-port read data, registered, valid one cycle after addr.
REQ-008 bus_req  output  1  request for the data-memory master port.
REQ-009 bus_gnt  input  1  grant of the master port from the external arbiter.
REQ-010 we_m  output  1  master-port write enable.
REQ-011 addr_m  output  32  master-port byte address.
REQ-012 wd_m  output  32  master-port write data.
REQ-013 rd_m  input  32  master-port read data, valid one cycle after addr_m is presented.
REQ-014 irq  output  1  one-cycle pulse on copy completion.

Function
REQ-015 Register map (offset addr[3:2]): 0 SRC, 1 DST, 2 LEN (LEN_W bits, zero-extended on read), 3 CTRL/STATUS.
REQ-016 SRC/DST writes shall force bits [1:0] to 0; reads return the stored value.
REQ-017 CTRL write: bit0=1 starts a copy; bit2=1 clears sticky DONE; other bits ignored.
REQ-018 STATUS read: bit1 BUSY, bit2 DONE, all other bits 0.
REQ-019 Writes to SRC, DST and LEN while BUSY shall be ignored.
REQ-020 A start while BUSY shall be ignored.
REQ-021 Start and DONE-clear in the same write: DONE cleared, copy started.
REQ-022 FSM states: IDLE, READ, WAIT, WRITE, FINISH.
REQ-023 IDLE: on start with LEN!=0, load working src/dst/count, set BUSY, go to READ; with LEN==0, go to FINISH without any bus access.
REQ-024 READ: bus_req=1; if bus_gnt=1 drive addr_m=src, we_m=0 and go to WAIT; else stay, we_m=0.
REQ-025 WAIT: bus_req=1, we_m=0; capture rd_m into the data register at the clock edge; go to WRITE.
REQ-026 WRITE: bus_req=1; if bus_gnt=1 drive addr_m=dst, wd_m=data, we_m=1, increment src and dst by 4 (mod 2^32), decrement count, then go to READ if count>1, else FINISH; if bus_gnt=0 stall with we_m=0.
REQ-027 FINISH: clear BUSY, set DONE, pulse irq for exactly one cycle, return to IDLE.
REQ-028 Minimum throughput: 3 cycles per word with bus_gnt held high; a copy of N words completes in 3N+2 cycles from the start write to irq.
REQ-029 Outside READ and WRITE with grant, we_m=0 and addr_m/wd_m hold their last values.
REQ-030 bus_gnt deasserted during WAIT shall not affect the capture (the read is already issued).
REQ-031 The config port remains readable at all times; the master port never addresses the engine itself.

Reset
REQ-032 On reset low: FSM=IDLE; SRC, DST, LEN, working registers, data register = 0; BUSY=DONE=0; rd, we_m, addr_m, wd_m, bus_req, irq = 0.
REQ-033 Reset asserted mid-copy aborts immediately; no further master write occurs after deassertion.

Verification
REQ-034 SRC=0x1000, DST=0x1100, LEN=4, start, gnt=1, memory model with 1-cycle read -> 4 writes of source words to 0x1100..0x110C, irq after 14 cycles, STATUS=0x4.
REQ-035 LEN=0, start -> no we_m pulse, irq in cycle 2, DONE=1.
REQ-036 LEN=2, gnt toggled low for 5 cycles in READ and in WRITE -> stalls without we_m, data still correct, irq delayed by 10 cycles.
REQ-037 Start while BUSY plus SRC write -> ignored; original copy completes unchanged.
REQ-038 SRC=0xFFFF_FFFC, LEN=2 -> second read at 0x0000_0000 (wrap).
REQ-039 Reset low after 2nd write of LEN=8 copy -> all outputs 0, STATUS=0, no write after release.
